// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// with one 32-bit word per line, sitting between a stalling datapath and a
// fixed-latency main memory.
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_b        - synchronous active-low reset
//   cpu_req      - datapath access request
//   cpu_we       - 1 = store, 0 = load
//   cpu_addr     - byte address (bits [1:0] ignored)
//   cpu_wdata    - store data, byte lanes, lane 0 least significant
//   cpu_rdata    - load data, byte lanes
//   cpu_ready    - access completes this cycle
//   mem_addr     - word-aligned address to main memory
//   mem_data_in  - write data to main memory
//   mem_data_out - read data from main memory
//   mem_we       - main memory write strobe
module data_cache #(
  parameter int XLEN        = 32,
  parameter int INDEX_BITS  = 3,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [XLEN-1:0]      cpu_addr,
  input  logic [3:0][7:0]      cpu_wdata,
  output logic [3:0][7:0]      cpu_rdata,
  output logic                 cpu_ready,
  output logic [XLEN-1:0]      mem_addr,
  output logic [3:0][7:0]      mem_data_in,
  input  logic [3:0][7:0]      mem_data_out,
  output logic                 mem_we
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = XLEN - INDEX_BITS - 2;
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  // Control state (reset)
  state_t              state;
  logic [3:0]          cnt;
  logic [LINES-1:0]    valid;
  logic [XLEN-1:0]     mem_addr_q;
  logic [3:0][7:0]     mem_data_in_q;
  logic                mem_we_q;

  // Storage and latched request (not reset)
  logic [TAG_W-1:0]    tags [LINES];
  logic [3:0][7:0]     data [LINES];
  logic [XLEN-3:0]     lat_word;
  logic [3:0][7:0]     lat_wdata;
  logic                lat_hit;

  // Byte-offset bits are intentionally ignored.
  logic                unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[1:0];

  // Lookup on the live request address (only meaningful in IDLE)
  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;

  assign req_index  = cpu_addr[INDEX_BITS+1:2];
  assign req_tag    = cpu_addr[XLEN-1:INDEX_BITS+2];
  assign lookup_hit = valid[req_index] && (tags[req_index] == req_tag);

  // Latched request fields used while a memory transaction is in flight
  logic [INDEX_BITS-1:0] lat_index;
  logic [TAG_W-1:0]      lat_tag;

  assign lat_index = lat_word[INDEX_BITS-1:0];
  assign lat_tag   = lat_word[XLEN-3:INDEX_BITS];

  logic last_cycle;
  assign last_cycle = (cnt == LAST_CNT);

  // Event strobes shared by the control and storage blocks. All of them are
  // suppressed while reset is asserted, so an aborted transaction never
  // touches the line storage.
  logic accept;
  logic fill_done;
  logic write_done;

  assign accept     = rst_b && (state == IDLE) && cpu_req && (cpu_we || !lookup_hit);
  assign fill_done  = rst_b && (state == FILL) && last_cycle;
  assign write_done = rst_b && (state == WRITE) && last_cycle;

  // Datapath-facing outputs: a read hit answers combinationally in IDLE,
  // a fill forwards memory data straight through on its final cycle.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    if (rst_b) begin
      case (state)
        IDLE: begin
          if (cpu_req && !cpu_we && lookup_hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = data[req_index];
          end
        end
        FILL: begin
          if (last_cycle) begin
            cpu_ready = 1'b1;
            cpu_rdata = mem_data_out;
          end
        end
        WRITE: begin
          if (last_cycle) begin
            cpu_ready = 1'b1;
          end
        end
        default: begin
          cpu_ready = 1'b0;
          cpu_rdata = '0;
        end
      endcase
    end
  end

  // Memory-facing outputs are registered: loaded on acceptance, held for the
  // whole transaction, and cleared on completion or reset.
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_we      = mem_we_q;

  // Control FSM
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      valid         <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt           <= 4'd0;
            mem_addr_q    <= {cpu_addr[XLEN-1:2], 2'b00};
            mem_data_in_q <= cpu_we ? cpu_wdata : '0;
            mem_we_q      <= cpu_we;
            state         <= cpu_we ? WRITE : FILL;
          end
        end
        FILL, WRITE: begin
          if (last_cycle) begin
            if (state == FILL) begin
              valid[lat_index] <= 1'b1;
            end
            cnt           <= 4'd0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            state         <= IDLE;
          end else if (cnt != 4'hF) begin
            // Saturating count; MEM_LATENCY <= 15 keeps it from ever reaching
            // the cap inside a legal transaction.
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line storage and request latch
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_word  <= cpu_addr[XLEN-1:2];
      lat_wdata <= cpu_wdata;
      lat_hit   <= lookup_hit;
    end
    if (fill_done) begin
      tags[lat_index] <= lat_tag;
      data[lat_index] <= mem_data_out;
    end
    // Write-through, no-allocate: only refresh a line that was resident
    // when the store was accepted.
    if (write_done && lat_hit) begin
      data[lat_index] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a simple
// word-addressed main memory model that answers combinationally and
// commits writes on every edge where mem_we is high.
module tb_data_cache;

  logic            clk;
  logic            rst_b;
  logic            cpu_req;
  logic            cpu_we;
  logic [31:0]     cpu_addr;
  logic [3:0][7:0] cpu_wdata;
  logic [3:0][7:0] cpu_rdata;
  logic            cpu_ready;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_data_in;
  logic [3:0][7:0] mem_data_out;
  logic            mem_we;

  int tests = 0;
  int fails = 0;

  data_cache #(.XLEN(32), .INDEX_BITS(3), .MEM_LATENCY(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_we       (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory model
  logic        mem_clear;
  logic [31:0] tb_mem [64];
  logic [63:0] written;

  function automatic logic [31:0] init_word(input logic [5:0] idx);
    case (idx)
      6'd4:    init_word = 32'hDEAD_BEEF;
      6'd12:   init_word = 32'h1111_2222;
      6'd17:   init_word = 32'hA5A5_5A5A;
      default: init_word = {26'h0, idx} ^ 32'h5000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_clear) begin
      written <= '0;
    end else if (mem_we) begin
      tb_mem[mem_addr[7:2]]  <= mem_data_in;
      written[mem_addr[7:2]] <= 1'b1;
    end
  end

  assign mem_data_out = written[mem_addr[7:2]] ? tb_mem[mem_addr[7:2]]
                                               : init_word(mem_addr[7:2]);

  function automatic logic [31:0] mem_word(input logic [5:0] idx);
    mem_word = written[idx] ? tb_mem[idx] : init_word(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access: counts cycles from request to cpu_ready (request
  // cycle counts as 1) and checks the memory side on every in-flight cycle.
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat,
                           input logic [31:0] exp_rdata);
    int n;
    n = 1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    while (!cpu_ready && n < 30) begin
      tick();
      n++;
      chk({tag, "_maddr"}, mem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "_mwe"}, {31'h0, mem_we}, {31'h0, we});
      if (we) chk({tag, "_mdin"}, mem_data_in, wdata);
    end
    chk({tag, "_lat"}, n, exp_lat);
    if (!we) chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    rst_b     = 1'b0;
    mem_clear = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    tick();
    tick();
    mem_clear = 1'b0;
    chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rst_mwe",   {31'h0, mem_we},    32'h0);
    chk("rst_maddr", mem_addr,    32'h0);
    chk("rst_mdin",  mem_data_in, 32'h0);
    chk("rst_rdata", cpu_rdata,   32'h0);
    rst_b = 1'b1;
    tick();
    chk("idle_ready", {31'h0, cpu_ready}, 32'h0);
    chk("idle_mwe",   {31'h0, mem_we},    32'h0);

    // Cold miss then hit
    do_access("ld10_miss", 1'b0, 32'h10, 32'h0, 5, 32'hDEAD_BEEF);
    do_access("ld10_hit",  1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF);

    // Store hit updates line and memory
    do_access("st10", 1'b1, 32'h10, 32'hCAFE_F00D, 5, 32'h0);
    chk("mem10", mem_word(6'd4), 32'hCAFE_F00D);
    do_access("ld10_after_st", 1'b0, 32'h13, 32'h0, 1, 32'hCAFE_F00D);

    // Store miss: no allocate
    do_access("st20", 1'b1, 32'h20, 32'h1234_5678, 5, 32'h0);
    chk("mem20", mem_word(6'd8), 32'h1234_5678);
    do_access("ld20_miss", 1'b0, 32'h20, 32'h0, 5, 32'h1234_5678);
    do_access("ld20_hit",  1'b0, 32'h20, 32'h0, 1, 32'h1234_5678);

    // Conflict eviction on index 4
    do_access("ld30_miss",   1'b0, 32'h30, 32'h0, 5, 32'h1111_2222);
    do_access("ld10_evict",  1'b0, 32'h10, 32'h0, 5, 32'hCAFE_F00D);
    do_access("ld10_rehit",  1'b0, 32'h10, 32'h0, 1, 32'hCAFE_F00D);

    // Inputs change and request drops mid-fill
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h44;
    #1;
    chk("f_req_ready", {31'h0, cpu_ready}, 32'h0);
    tick();
    chk("f_c1_maddr", mem_addr, 32'h44);
    chk("f_c1_mwe", {31'h0, mem_we}, 32'h0);
    tick();
    cpu_addr  = 32'h10;
    cpu_req   = 1'b0;
    cpu_we    = 1'b1;
    cpu_wdata = 32'hFFFF_FFFF;
    #1;
    chk("f_c2_maddr", mem_addr, 32'h44);
    chk("f_c2_mwe", {31'h0, mem_we}, 32'h0);
    tick();
    chk("f_c3_ready", {31'h0, cpu_ready}, 32'h0);
    tick();
    chk("f_c4_ready", {31'h0, cpu_ready}, 32'h1);
    chk("f_c4_rdata", cpu_rdata, 32'hA5A5_5A5A);
    chk("f_c4_maddr", mem_addr, 32'h44);
    tick();
    chk("f_idle_ready", {31'h0, cpu_ready}, 32'h0);
    chk("f_idle_maddr", mem_addr, 32'h0);
    chk("f_idle_mwe", {31'h0, mem_we}, 32'h0);
    cpu_we = 1'b0;
    do_access("ld44_hit",  1'b0, 32'h44, 32'h0, 1, 32'hA5A5_5A5A);
    do_access("ld10_kept", 1'b0, 32'h10, 32'h0, 1, 32'hCAFE_F00D);

    // Reset in the 3rd write cycle
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h10;
    cpu_wdata = 32'h0BAD_CAFE;
    #1;
    chk("w_req_ready", {31'h0, cpu_ready}, 32'h0);
    tick();
    tick();
    tick();
    chk("w_c3_mwe", {31'h0, mem_we}, 32'h1);
    chk("w_c3_maddr", mem_addr, 32'h10);
    chk("w_c3_mdin", mem_data_in, 32'h0BAD_CAFE);
    rst_b   = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();
    chk("w_rst_mwe", {31'h0, mem_we}, 32'h0);
    chk("w_rst_maddr", mem_addr, 32'h0);
    chk("w_rst_mdin", mem_data_in, 32'h0);
    chk("w_rst_ready", {31'h0, cpu_ready}, 32'h0);
    chk("w_rst_rdata", cpu_rdata, 32'h0);
    rst_b = 1'b1;
    tick();
    // Memory saw the strobe for three edges; cache lines are all invalid.
    do_access("ld10_post_rst", 1'b0, 32'h10, 32'h0, 5, 32'h0BAD_CAFE);
    do_access("ld44_post_rst", 1'b0, 32'h44, 32'h0, 5, 32'hA5A5_5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter XLEN, default 32, sets data and address width in bits.
REQ-002 Parameter INDEX_BITS, default 3, sets the line count to 2^INDEX_BITS; each line holds one word.
REQ-003 Parameter MEM_LATENCY, default 4, is the number of cycles memory needs per access; legal range is 2..15.
REQ-004 clk  in  1  is the single clock; every state change occurs on its rising edge.
REQ-005 rst_b  in  1  is the reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-006 cpu_req  in  1  is the datapath's memory access request.
REQ-007 cpu_we  in  1  selects the access type: 1 = store, 0 = load.
REQ-008 cpu_addr  in  XLEN  is the byte address; bits [1:0] are ignored.
REQ-009 cpu_wdata  in  4x8  is the store data in byte lanes, lane 0 least significant.
REQ-010 cpu_rdata  out  4x8  is the load data in byte lanes.
REQ-011 cpu_ready  out  1  signals that the access completes this cycle; the datapath stalls while cpu_req=1 and cpu_ready=0.
REQ-012 mem_addr  out  XLEN  is the word-aligned address to main memory.
REQ-013 mem_data_in  out  4x8  is the write data to main memory.
REQ-014 mem_data_out  in  4x8  is the read data from main memory.
REQ-015 mem_we  out  1  is the main memory write strobe.

Function
REQ-016 Mapping: direct-mapped; index = addr[INDEX_BITS+1:2]; tag = addr[XLEN-1:INDEX_BITS+2].
REQ-017 Policy: write-through, no-write-allocate; each line has a valid bit, a tag and one data word.
REQ-018 FSM states are IDLE, FILL and WRITE.
REQ-019 IDLE read hit (valid and tag match): cpu_ready=1 and cpu_rdata=line data combinationally in the same cycle; state stays IDLE.
REQ-020 IDLE read miss: cpu_ready=0; at the next edge the cache latches the address, clears the counter and enters FILL.
REQ-021 IDLE store: cpu_ready=0; at the next edge the cache latches the address and data, clears the counter and enters WRITE.
REQ-022 FILL: mem_addr = latched word address and mem_we=0 for MEM_LATENCY cycles.
REQ-023 FILL final cycle (counter = MEM_LATENCY-1): cpu_ready=1 and cpu_rdata=mem_data_out; at the edge the line is written with valid=1 and the new tag, and the state returns to IDLE.
REQ-024 WRITE: mem_addr, mem_data_in and mem_we=1 are held stable for MEM_LATENCY cycles.
REQ-025 WRITE final cycle: cpu_ready=1; at the edge the line data is updated only if the line hit at latch time, then the state returns to IDLE.
REQ-026 Load latency is 0 extra cycles on a hit and MEM_LATENCY+1 cycles from request to cpu_ready on a miss.
REQ-027 Store latency is always MEM_LATENCY+1 cycles, hit or miss.
REQ-028 While in FILL or WRITE, the cache uses only latched values; cpu_addr, cpu_we and cpu_wdata are ignored.
REQ-029 If cpu_req deasserts mid-transaction, the transaction still completes in full: the fill is written and the store is performed.
REQ-030 cpu_req=0 in IDLE: cpu_ready=0, mem_we=0, no state change.
REQ-031 A new request is accepted only in IDLE; there is no back-to-back overlap, so the cycle after a final cycle is IDLE.
REQ-032 The counter is a 4-bit value, saturated by construction; it never wraps within a transaction.
REQ-033 Outside the active states: mem_addr=0, mem_data_in=0, mem_we=0, cpu_rdata=0 unless a hit is driving it.

Reset
REQ-034 When rst_b=0 at an edge: state=IDLE, counter=0 and all valid bits=0; tags and data may hold any value.
REQ-035 Outputs during and after reset: cpu_ready=0, mem_we=0, mem_addr=0, mem_data_in=0, cpu_rdata=0.
REQ-036 Reset asserted mid-FILL or mid-WRITE aborts the transaction: no line is written, and mem_we drops to 0 at that edge.

Verification
REQ-037 After reset, load 0x0000_0010 -> cpu_ready=0 for 4 cycles, then 1 with memory word 0xDEAD_BEEF; a repeat load of the same address gets ready in the same cycle.
REQ-038 Store 0xCAFE_F00D to cached 0x10 -> mem_we=1 for 4 cycles at mem_addr 0x10, then ready; a following load of 0x10 hits and returns 0xCAFE_F00D.
REQ-039 Store to uncached 0x20 -> memory is written, then a load of 0x20 misses (no allocate) and takes 5 cycles.
REQ-040 Conflict: load 0x10 (index 4), then load 0x30 (index 4, different tag) misses and evicts; a following load of 0x10 misses again.
REQ-041 cpu_addr changed and cpu_req dropped in the 2nd FILL cycle -> memory address stays on the original; the line is filled with the original tag.
REQ-042 rst_b=0 in the 3rd WRITE cycle -> mem_we=0 next cycle, all lines invalid, and a following load of a previously cached address misses.
